// File: rtl/icsp_pkg.sv
// Shared command codes, field sizes and FSM state type for the ICSP program loader.
package icsp_pkg;

  localparam int CMD_BITS   = 6;
  localparam int FRAME_BITS = 16;

  localparam logic [CMD_BITS-1:0] CMD_LOAD_DATA  = 6'h02;
  localparam logic [CMD_BITS-1:0] CMD_READ_DATA  = 6'h04;
  localparam logic [CMD_BITS-1:0] CMD_INC_ADDR   = 6'h06;
  localparam logic [CMD_BITS-1:0] CMD_BEGIN_PROG = 6'h08;

  typedef enum logic [2:0] {IDLE, CMD, LOAD, READ, PROG} state_t;

endpackage

// File: rtl/icsp_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, with single-cycle rise/fall pulses.
module icsp_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync_q;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync_q <= 1'b0;
      prev   <= 1'b0;
    end else begin
      meta   <= async_in;
      sync_q <= meta;
      prev   <= sync_q;
    end
  end

  assign rise = sync_q & ~prev;
  assign fall = ~sync_q & prev;

endmodule

// File: rtl/icsp_program_loader.sv
// ICSP serial programming port writing instruction words into program memory.
// Readback of program memory (Read Data command) is built only when ICSP_READBACK_EN is defined.
module icsp_program_loader
  import icsp_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 14,
  parameter int PROG_CYCLES = 16
) (
  input  logic              master_clk,
  input  logic              reset,
  input  logic              prog_mode,
  input  logic              icsp_clk,
  input  logic              icsp_data_in,
  output logic              icsp_data_out,
  output logic              icsp_data_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam int BSY_W = $clog2(PROG_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CMD_BIT   = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_FRAME_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [BSY_W-1:0] BUSY_RELOAD    = BSY_W'(PROG_CYCLES - 1);

  state_t            state, state_next;
  logic              clk_rise, clk_fall, pm_rise, pm_fall;
  logic [1:0]        din_sync;
  logic [DATA_W-1:0] shift_in;
  logic [DATA_W:0]   shift_next;
  logic [CMD_BITS-1:0] cmd_code;
  logic [CNT_W-1:0]  bit_cnt;
  logic [BSY_W-1:0]  busy_cnt;
  logic              clk_fall_ok, cmd_done, frame_done;

  icsp_sync_edge u_clk_sync (
    .clk(master_clk), .rst_n(reset), .async_in(icsp_clk), .rise(clk_rise), .fall(clk_fall)
  );

  icsp_sync_edge u_pm_sync (
    .clk(master_clk), .rst_n(reset), .async_in(prog_mode), .rise(pm_rise), .fall(pm_fall)
  );

  // Newest bit enters at the top; after a full frame the data bits sit in shift_next[DATA_W-1:0].
  assign shift_next  = {din_sync[1], shift_in};
  assign cmd_code    = shift_next[DATA_W -: CMD_BITS];
  assign clk_fall_ok = clk_fall & ~busy;
  assign cmd_done    = (state == CMD) && clk_fall_ok && (bit_cnt == LAST_CMD_BIT);
  assign frame_done  = ((state == LOAD) || (state == READ)) && clk_fall_ok &&
                       (bit_cnt == LAST_FRAME_BIT);

  always_ff @(posedge master_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (pm_fall) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (pm_rise) state_next = CMD;
        CMD: begin
          if (cmd_done) begin
            case (cmd_code)
              CMD_LOAD_DATA:  state_next = LOAD;
`ifdef ICSP_READBACK_EN
              CMD_READ_DATA:  state_next = READ;
`endif
              CMD_BEGIN_PROG: state_next = PROG;
              default:        state_next = CMD;
            endcase
          end
        end
        LOAD:    if (frame_done) state_next = CMD;
        READ:    if (frame_done) state_next = CMD;
        PROG:    state_next = CMD;
        default: state_next = IDLE;
      endcase
    end
  end

  // The strobe is suppressed in the cycle an abort is seen so no write escapes.
  always_comb begin
    mem_wr_en = 1'b0;
    busy      = (busy_cnt != '0);
    if (state == PROG) begin
      busy      = 1'b1;
      mem_wr_en = ~pm_fall;
    end
  end

  always_ff @(posedge master_clk or negedge reset) begin
    if (!reset) begin
      din_sync    <= '0;
      shift_in    <= '0;
      bit_cnt     <= '0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      busy_cnt    <= '0;
    end else begin
      din_sync <= {din_sync[0], icsp_data_in};
      if (clk_fall_ok && (state == CMD || state == LOAD || state == READ)) begin
        shift_in <= shift_next[DATA_W:1];
        bit_cnt  <= bit_cnt + 1'b1;
      end
      if (cmd_done || (state_next != state)) bit_cnt <= '0;
      if (state == IDLE && state_next == CMD) mem_addr <= '0;
      if (cmd_done && !pm_fall && cmd_code == CMD_INC_ADDR) mem_addr <= mem_addr + 1'b1;
      if (state == LOAD && frame_done && !pm_fall) mem_wr_data <= shift_next[DATA_W-1:0];
      if (state == PROG && !pm_fall) busy_cnt <= BUSY_RELOAD;
      else if (busy_cnt != '0)       busy_cnt <= busy_cnt - 1'b1;
    end
  end

`ifdef ICSP_READBACK_EN
  logic [FRAME_BITS-1:0] read_frame, out_shift;
  logic                  out_bit, out_en;

  assign read_frame = {1'b0, mem_rd_data, 1'b0};

  // The frame is captured on the first rising edge so the memory has had the whole command to settle.
  always_ff @(posedge master_clk or negedge reset) begin
    if (!reset) begin
      out_shift <= '0;
      out_bit   <= 1'b0;
      out_en    <= 1'b0;
    end else if (state_next != READ) begin
      out_shift <= '0;
      out_bit   <= 1'b0;
      out_en    <= 1'b0;
    end else if (clk_rise && !busy) begin
      if (!out_en) begin
        out_en    <= 1'b1;
        out_bit   <= read_frame[0];
        out_shift <= read_frame >> 1;
      end else begin
        out_bit   <= out_shift[0];
        out_shift <= out_shift >> 1;
      end
    end
  end

  assign icsp_data_out = out_bit;
  assign icsp_data_oe  = out_en;
`else
  logic unused_readback;
  assign unused_readback = clk_rise ^ (^mem_rd_data);
  assign icsp_data_out   = 1'b0;
  assign icsp_data_oe    = 1'b0;
`endif

endmodule

// File: tb/tb_icsp_program_loader.sv
// Directed self-checking bench for icsp_program_loader; honours ICSP_READBACK_EN.
module tb_icsp_program_loader;

  localparam int ADDR_W      = 6;
  localparam int DATA_W      = 14;
  localparam int PROG_CYCLES = 16;
  localparam int HALF        = 60;

  logic              master_clk = 1'b0;
  logic              reset = 1'b0;
  logic              prog_mode = 1'b0;
  logic              icsp_clk = 1'b0;
  logic              icsp_data_in = 1'b0;
  logic              icsp_data_out, icsp_data_oe, mem_wr_en, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data = '0;

  int tests_run = 0;
  int tests_failed = 0;
  int wr_count = 0;
  int busy_total = 0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;

  always #5 master_clk = ~master_clk;

  icsp_program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PROG_CYCLES(PROG_CYCLES)) dut (
    .master_clk(master_clk), .reset(reset), .prog_mode(prog_mode), .icsp_clk(icsp_clk),
    .icsp_data_in(icsp_data_in), .icsp_data_out(icsp_data_out), .icsp_data_oe(icsp_data_oe),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .busy(busy)
  );

  // Memory-side observer: records every write strobe and every busy cycle.
  always @(negedge master_clk) begin
    if (mem_wr_en) begin
      wr_count <= wr_count + 1;
      wr_addr  <= mem_addr;
      wr_data  <= mem_wr_data;
    end
    if (busy) busy_total <= busy_total + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      icsp_data_in = bits[i];
      icsp_clk = 1'b1;
      #HALF;
      icsp_clk = 1'b0;
      #HALF;
    end
  endtask

  task automatic send_cmd(input logic [5:0] code);
    applyStimulus({26'h0, code}, 6);
  endtask

  // Start and stop bits are sent as 1 to show they are ignored.
  task automatic load_word(input logic [DATA_W-1:0] d);
    send_cmd(6'h02);
    applyStimulus({16'h0, 1'b1, d, 1'b1}, 16);
  endtask

  task automatic program_word(input string tag, input logic [DATA_W-1:0] d,
                              input logic [ADDR_W-1:0] exp_addr);
    int w0, b0;
    load_word(d);
    w0 = wr_count;
    b0 = busy_total;
    send_cmd(6'h08);
    repeat (40) @(negedge master_clk);
    checkOutput({tag, "_strobes"}, wr_count - w0, 1);
    checkOutput({tag, "_addr"}, wr_addr, exp_addr);
    checkOutput({tag, "_data"}, wr_data, d);
    checkOutput({tag, "_busy_cycles"}, busy_total - b0, PROG_CYCLES);
    checkOutput({tag, "_busy_done"}, busy, 0);
  endtask

  initial begin
    int w0, oe_count;
    logic [15:0] rx;

    repeat (3) @(negedge master_clk);
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_wr_en", mem_wr_en, 0);
    checkOutput("rst_wr_data", mem_wr_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_oe", icsp_data_oe, 0);
    checkOutput("rst_dout", icsp_data_out, 0);
    reset = 1'b1;
    repeat (3) @(negedge master_clk);

    prog_mode = 1'b1;
    repeat (10) @(negedge master_clk);
    checkOutput("entry_addr", mem_addr, 0);
    program_word("prog0", 14'h0C85, 6'd0);
    checkOutput("latch_0c85", mem_wr_data, 14'h0C85);

    for (int i = 0; i < 3; i++) send_cmd(6'h06);
    checkOutput("inc3_addr", mem_addr, 3);
    program_word("prog3", 14'h3FFF, 6'd3);

    for (int i = 0; i < (1 << ADDR_W) - 4; i++) send_cmd(6'h06);
    checkOutput("addr_max", mem_addr, 6'h3F);
    send_cmd(6'h06);
    checkOutput("addr_wrap", mem_addr, 0);

    w0 = wr_count;
    send_cmd(6'h3F);
    send_cmd(6'h06);
    checkOutput("unknown_then_inc", mem_addr, 1);
    checkOutput("unknown_no_write", wr_count - w0, 0);

    mem_rd_data = 14'h2A5A;
    send_cmd(6'h04);
    oe_count = 0;
    rx = '0;
`ifdef ICSP_READBACK_EN
    for (int i = 0; i < 16; i++) begin
`else
    for (int i = 0; i < 12; i++) begin
`endif
      icsp_data_in = 1'b0;
      icsp_clk = 1'b1;
      #(HALF - 10);
      if (icsp_data_oe === 1'b1) oe_count++;
      rx[i] = icsp_data_out;
      #10;
      icsp_clk = 1'b0;
      #HALF;
    end
`ifdef ICSP_READBACK_EN
    checkOutput("read_oe_bits", oe_count, 16);
    checkOutput("read_stream", rx, 16'h54B4);
`else
    checkOutput("read_disabled_oe", oe_count, 0);
    checkOutput("read_disabled_dout", rx, 0);
`endif
    repeat (5) @(negedge master_clk);
    checkOutput("read_oe_off", icsp_data_oe, 0);
    send_cmd(6'h06);
    checkOutput("after_read_inc", mem_addr, 2);

    w0 = wr_count;
    send_cmd(6'h02);
    applyStimulus(32'hA5, 8);
    prog_mode = 1'b0;
    repeat (10) @(negedge master_clk);
    checkOutput("abort_addr_kept", mem_addr, 2);
    checkOutput("abort_oe", icsp_data_oe, 0);
    prog_mode = 1'b1;
    repeat (10) @(negedge master_clk);
    checkOutput("reentry_addr", mem_addr, 0);
    checkOutput("abort_no_write", wr_count - w0, 0);
    checkOutput("abort_latch_kept", mem_wr_data, 14'h3FFF);
    send_cmd(6'h06);
    checkOutput("reentry_inc", mem_addr, 1);

    load_word(14'h0155);
    send_cmd(6'h08);
    checkOutput("busy_before_reset", busy, 1);
    checkOutput("strobe_before_reset", wr_data, 14'h0155);
    reset = 1'b0;
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_wr_en", mem_wr_en, 0);
    checkOutput("reset_addr", mem_addr, 0);
    checkOutput("reset_wr_data", mem_wr_data, 0);
    #9;
    reset = 1'b1;
    repeat (5) @(negedge master_clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/icsp_program_loader.md
Name: icsp_program_loader

Overview:
- Serial in-circuit programming port that writes 14-bit instruction words into the flash program memory; the PC-driven instruction fetch only reads that memory, and this block is the writer on the other side of it.
- Host drives a PIC-style ICSP link (icsp_clk, bidirectional data) while prog_mode is high.
- The block decodes 6-bit commands, shifts 16-bit data frames in or out, and issues single-cycle write strobes to the program memory's write port.
- Sits beside pc/flash_program_memory in the pic top, clocked by master_clk.

Parameters:
- ADDR_W, 12, program-memory address width; matches the pc width.
- DATA_W, 14, instruction word width.
- PROG_CYCLES, 16, master_clk cycles busy is held after a write strobe.

Ports:
- master_clk  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- prog_mode  in  1  programming-mode enable (MCLR/Vpp equivalent), asynchronous to master_clk.
- icsp_clk  in  1  host serial clock, asynchronous to master_clk, at most master_clk/8.
- icsp_data_in  in  1  host serial data.
- icsp_data_out  out  1  device serial data during Read Data.
- icsp_data_oe  out  1  high while the device drives the data line.
- mem_addr  out  ADDR_W  program-memory address.
- mem_wr_en  out  1  one-cycle write strobe.
- mem_wr_data  out  DATA_W  word to write.
- mem_rd_data  in  DATA_W  memory read data at mem_addr, valid 2 cycles after mem_addr changes.
- busy  out  1  write in progress.

Behaviour:
- Reset (reset=0): state IDLE, mem_addr=0, data latch=0, mem_wr_en=0, icsp_data_out=0, icsp_data_oe=0, busy=0.
- Synchronisation: prog_mode, icsp_clk and icsp_data_in each pass through 2-flop synchronisers. Edge detect on the synced icsp_clk.
- Bit timing: input bits are sampled on icsp_clk falling edges. Output bits change on icsp_clk rising edges.
- Bit order: all fields are LSB first.
- Command field: 6 bits.
- Data frame: 16 bits = start bit 0, DATA_W data bits, stop bit 0. Start/stop values received from the host are ignored.
- FSM states: IDLE, CMD, LOAD, READ, PROG.
  - IDLE: when synced prog_mode rises → mem_addr=0, go to CMD.
  - CMD: after 6 falling edges, decode:
    - 0x02 Load Data → LOAD.
    - 0x04 Read Data → READ.
    - 0x06 Increment Address → mem_addr+1, wraps 2^ADDR_W-1 → 0; stay in CMD.
    - 0x08 Begin Programming → PROG.
    - Any other code → discarded, stay in CMD.
  - LOAD: shift 16 bits. On the 16th falling edge, data latch = data bits [14:1] → CMD.
  - READ: on the first rising edge, load {0, mem_rd_data, 0} into the shift register and raise icsp_data_oe. One bit is driven per rising edge. After the 16th falling edge, icsp_data_oe=0 → CMD.
  - PROG: mem_wr_en=1 for exactly one master_clk cycle, with mem_addr and mem_wr_data=latch. busy=1 from that cycle for PROG_CYCLES cycles, then → CMD.
- icsp_clk edges while busy: ignored (not counted); the host must wait for busy=0.
- prog_mode falling in any state: abort immediately to IDLE, icsp_data_oe=0, no write strobe issued. A pending busy count is allowed to finish. mem_addr is retained until the next entry, where it resets to 0.
- Asynchronous reset mid-frame or mid-PROG: all outputs take their reset values immediately; no partial write.
- mem_wr_data: always reflects the data latch.
- Address wrap: occurs only via Increment Address.

Optional Feature:
- Macro ICSP_READBACK_EN.
- Defined: Read Data (0x04) is supported as described above.
- Undefined: 0x04 is treated as an unknown command, no READ state or output shift register is built, and icsp_data_out/icsp_data_oe are tied to 0.

Decomposition:
- Shared package icsp_pkg holds:
  - command codes CMD_LOAD_DATA=6'h02, CMD_READ_DATA=6'h04, CMD_INC_ADDR=6'h06, CMD_BEGIN_PROG=6'h08;
  - CMD_BITS=6 and FRAME_BITS=16;
  - the FSM state enum.
- One sub-module, icsp_sync_edge: 2-flop synchroniser plus rise/fall pulse outputs, instantiated for icsp_clk and prog_mode. icsp_data_in uses the synchroniser only.

Test Plan:
- Enter prog_mode, send Load Data with 0x0C85, then Begin Programming → mem_wr_en high for 1 cycle with mem_addr=0, mem_wr_data=0x0C85; busy high for 16 cycles.
- Increment Address ×3, then Load 0x3FFF + Begin Programming → write at mem_addr=3, data 0x3FFF.
- Increment Address 4096 times → mem_addr returns to 0x000 (wrap).
- With mem_rd_data=0x2A5A, send Read Data → oe high for 16 clocks; serial stream 0, 0x2A5A LSB first, 0. Without ICSP_READBACK_EN → oe stays 0 and no state change.
- Send unknown command 0x3F, then Increment Address → only the increment takes effect (mem_addr=1); no write strobe.
- Drop prog_mode after 8 bits of a Load frame, then re-enter → state IDLE→CMD, mem_addr=0, no mem_wr_en. Assert reset during busy → busy=0 immediately.
